// File: rtl/bus_interconnect.sv
// PicoRV32 native-bus interconnect: decodes ROM/RAM/IO windows, sequences one
// transfer at a time and folds stalled or unmapped accesses into a sticky error.
module bus_interconnect #(
   parameter logic [31:0] ROM_BASE = 32'h0000_0000,
   parameter logic [31:0] ROM_SIZE = 32'h0000_1000,
   parameter logic [31:0] RAM_BASE = 32'h0000_1000,
   parameter logic [31:0] RAM_SIZE = 32'h0000_1000,
   parameter logic [31:0] IO_BASE  = 32'h1000_0000,
   parameter logic [31:0] IO_SIZE  = 32'h0000_1000,
   parameter int          TIMEOUT  = 16
) (
   input  logic        clk_in,
   input  logic        reset_n_in,
   input  logic        mem_valid_in,
   input  logic [31:0] mem_addr_in,
   input  logic [31:0] mem_wdata_in,
   input  logic [3:0]  mem_wstrb_in,
   output logic        mem_ready_out,
   output logic [31:0] mem_rdata_out,
   output logic [2:0]  sel_out,
   output logic        write_out,
   output logic [31:0] addr_out,
   output logic [31:0] wdata_out,
   output logic [3:0]  wstrb_out,
   input  logic [95:0] rdata_in,
   input  logic [2:0]  ready_in,
   input  logic        err_clr_in,
   output logic        bus_error_out,
   output logic [31:0] err_addr_out
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [31:0]   addr_q;

   logic [2:0]    dec_sel;
   logic [31:0]   dec_base;
   logic          rom_wr;
   logic          hit_ok;
   logic [31:0]   lane_rdata;
   logic          lane_rdy;
   logic          timed_out;
   logic          err_set;
   logic [31:0]   err_at;

   // 33-bit compare so BASE+SIZE never wraps at the top of memory
   function automatic logic in_win(input logic [31:0] a,
                                   input logic [31:0] base,
                                   input logic [31:0] size);
      logic [32:0] x, lo, hi;
      x  = {1'b0, a};
      lo = {1'b0, base};
      hi = lo + {1'b0, size};
      return (x >= lo) && (x < hi);
   endfunction

   always_comb begin
      dec_sel  = 3'b000;
      dec_base = 32'h0;
      if (in_win(mem_addr_in, ROM_BASE, ROM_SIZE)) begin
         dec_sel  = 3'b001;
         dec_base = ROM_BASE;
      end else if (in_win(mem_addr_in, RAM_BASE, RAM_SIZE)) begin
         dec_sel  = 3'b010;
         dec_base = RAM_BASE;
      end else if (in_win(mem_addr_in, IO_BASE, IO_SIZE)) begin
         dec_sel  = 3'b100;
         dec_base = IO_BASE;
      end
   end

   assign rom_wr = dec_sel[0] && (mem_wstrb_in != 4'h0);
   assign hit_ok = (dec_sel != 3'b000) && !rom_wr;

   always_comb begin
      lane_rdata = 32'h0;
      lane_rdy   = 1'b0;
      unique case (1'b1)
         sel_out[0]: begin
            lane_rdata = rdata_in[31:0];
            lane_rdy   = ready_in[0];
         end
         sel_out[1]: begin
            lane_rdata = rdata_in[63:32];
            lane_rdy   = ready_in[1];
         end
         sel_out[2]: begin
            lane_rdata = rdata_in[95:64];
            lane_rdy   = ready_in[2];
         end
         default: ;
      endcase
   end

   assign timed_out = (cnt == CW'(TIMEOUT - 1));

   always_comb begin
      err_set = 1'b0;
      err_at  = addr_q;
      case (state)
         IDLE: begin
            if (mem_valid_in && !hit_ok) begin
               err_set = 1'b1;
               err_at  = mem_addr_in;
            end
         end
         ACCESS: err_set = !lane_rdy && timed_out;
         default: ;
      endcase
   end

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state         <= IDLE;
         cnt           <= '0;
         addr_q        <= 32'h0;
         mem_ready_out <= 1'b0;
         mem_rdata_out <= 32'h0;
         sel_out       <= 3'b000;
         write_out     <= 1'b0;
         addr_out      <= 32'h0;
         wdata_out     <= 32'h0;
         wstrb_out     <= 4'h0;
         bus_error_out <= 1'b0;
         err_addr_out  <= 32'h0;
      end else begin
         mem_ready_out <= 1'b0;
         mem_rdata_out <= 32'h0;
         case (state)
            IDLE: begin
               if (mem_valid_in) begin
                  addr_q <= mem_addr_in;
                  if (hit_ok) begin
                     state     <= ACCESS;
                     cnt       <= '0;
                     sel_out   <= dec_sel;
                     write_out <= (mem_wstrb_in != 4'h0);
                     addr_out  <= mem_addr_in - dec_base;
                     wdata_out <= mem_wdata_in;
                     wstrb_out <= mem_wstrb_in;
                  end else begin
                     state         <= RESPOND;
                     mem_ready_out <= 1'b1;
                  end
               end
            end
            ACCESS: begin
               if (lane_rdy || timed_out) begin
                  state         <= RESPOND;
                  mem_ready_out <= 1'b1;
                  mem_rdata_out <= lane_rdy ? lane_rdata : 32'h0;
                  sel_out       <= 3'b000;
                  write_out     <= 1'b0;
                  addr_out      <= 32'h0;
                  wdata_out     <= 32'h0;
                  wstrb_out     <= 4'h0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            RESPOND: state <= IDLE;
            default: state <= IDLE;
         endcase
         // a new error in the clear cycle becomes the first error
         if (err_set) begin
            bus_error_out <= 1'b1;
            if (!bus_error_out || err_clr_in)
               err_addr_out <= err_at;
         end else if (err_clr_in) begin
            bus_error_out <= 1'b0;
            err_addr_out  <= 32'h0;
         end
      end
   end

endmodule
